// File: rtl/matrix_job_scheduler.sv
// Matrix job scheduler: queues CPU job descriptors and runs each job on
// the accelerator register port.
// Ports: clk, reset_n; wb_* CPU Wishbone slave; m_* accelerator
// Wishbone master; irq_o = done_pending | err.
module matrix_job_scheduler #(
  parameter int QUEUE_DEPTH  = 4,
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        irq_o
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam logic [31:0] TMO = 32'(POLL_TIMEOUT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_PDONE  = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_PIDLE  = 3'd5;
  localparam logic [2:0] S_RETIRE = 3'd6;
  localparam logic [2:0] S_ABORT  = 3'd7;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [15:0] rows;
    logic [15:0] acols;
    logic [15:0] cols;
  } job_t;

  job_t          q_mem [QUEUE_DEPTH];
  job_t          stage_q;
  job_t          head;
  logic [QW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   done_cnt_q, rdat_q;
  logic          ack_q, done_q, err_q, ovf_q;

  logic [2:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] tmo_q, tmo_d;
  logic        m_stb_q, m_stb_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_adr_q, m_adr_d;
  logic [31:0] m_dat_q, m_dat_d;

  logic        pop, retire, tmo_hit;
  logic        acc_we;
  logic [31:0] acc_adr, acc_dat;
  logic        is_poll;

  logic [4:0]  adr;
  logic        cpu_req, cpu_wr, cpu_rd;
  logic        cmd_wr, push_req, push_ok;
  logic        empty, full, busy;
  logic [7:0]  cnt8;
  logic [31:0] status, rmux;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[31:5];
  assign adr      = wb_adr_i[4:0];
  assign cpu_req  = wb_stb_i && !ack_q;
  assign cpu_wr   = cpu_req && wb_we_i;
  assign cpu_rd   = cpu_req && !wb_we_i;
  assign cmd_wr   = cpu_wr && (adr == 5'h14);
  assign push_req = cmd_wr && wb_dat_i[0];

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(QUEUE_DEPTH));
  assign busy    = (state_q != S_IDLE);
  assign push_ok = push_req && !full;
  assign head    = q_mem[head_q];
  assign cnt8    = 8'(cnt_q);

  assign status = {16'd0, cnt8, 2'b00,
                   ovf_q, err_q, done_q,
                   full, empty, busy};

  always_comb begin
    rmux = 32'hDEADBEEF;
    case (adr)
      5'h00: rmux = stage_q.a;
      5'h04: rmux = stage_q.b;
      5'h08: rmux = stage_q.c;
      5'h0C: rmux = {stage_q.acols, stage_q.rows};
      5'h10: rmux = {16'd0, stage_q.cols};
      5'h18: rmux = status;
      5'h1C: rmux = done_cnt_q;
      default: ;
    endcase
  end

  assign is_poll = (state_q == S_PDONE) ||
                   (state_q == S_PIDLE);

  always_comb begin
    acc_we  = 1'b1;
    acc_adr = 32'h0;
    acc_dat = 32'h0;
    case (state_q)
      S_CFG: begin
        case (step_q)
          3'd0: begin
            acc_adr = 32'h04;
            acc_dat = head.a;
          end
          3'd1: begin
            acc_adr = 32'h08;
            acc_dat = head.b;
          end
          3'd2: begin
            acc_adr = 32'h0C;
            acc_dat = head.c;
          end
          3'd3: begin
            acc_adr = 32'h10;
            acc_dat = {16'd0, head.rows};
          end
          3'd4: begin
            acc_adr = 32'h12;
            acc_dat = {16'd0, head.acols};
          end
          default: begin
            acc_adr = 32'h14;
            acc_dat = {16'd0, head.cols};
          end
        endcase
      end
      S_START: acc_dat = 32'd1;
      S_PDONE, S_PIDLE: begin
        acc_we  = 1'b0;
        acc_adr = 32'h16;
      end
      default: ;
    endcase
  end

  // The strobe drops on the ack edge and the next access launches one
  // cycle later, so every access is followed by one idle cycle. A poll
  // timeout is only taken between accesses so no access is cut short.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    m_stb_d = m_stb_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    pop     = 1'b0;
    retire  = 1'b0;
    tmo_hit = 1'b0;
    if (is_poll) tmo_d = tmo_q + 32'd1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_CFG;
          step_d  = 3'd0;
        end
      end
      S_RETIRE: begin
        pop     = 1'b1;
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        if (m_stb_q) begin
          if (m_ack_i) begin
            m_stb_d = 1'b0;
            case (state_q)
              S_CFG: begin
                if (step_q == 3'd5) state_d = S_START;
                else step_d = step_q + 3'd1;
              end
              S_START: begin
                state_d = S_PDONE;
                tmo_d   = 32'd0;
              end
              S_PDONE: begin
                if (m_dat_i == 32'd2) state_d = S_STOP;
              end
              S_STOP: begin
                state_d = S_PIDLE;
                tmo_d   = 32'd0;
              end
              S_PIDLE: begin
                if (m_dat_i == 32'd0) state_d = S_RETIRE;
              end
              S_ABORT: begin
                pop     = 1'b1;
                state_d = S_IDLE;
              end
              default: ;
            endcase
          end
        end else if (is_poll && (tmo_q >= TMO)) begin
          tmo_hit = 1'b1;
          state_d = S_ABORT;
        end else begin
          m_stb_d = 1'b1;
          m_we_d  = acc_we;
          m_adr_d = acc_adr;
          m_dat_d = acc_dat;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      tmo_q   <= 32'd0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= 32'h0;
      m_dat_q <= 32'h0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      m_stb_q <= m_stb_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      rdat_q     <= 32'h0;
      stage_q    <= '0;
      done_cnt_q <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        q_mem[i] <= '0;
    end else begin
      ack_q <= cpu_req;
      if (cpu_rd) rdat_q <= rmux;
      if (cpu_wr) begin
        case (adr)
          5'h00: stage_q.a <= wb_dat_i;
          5'h04: stage_q.b <= wb_dat_i;
          5'h08: stage_q.c <= wb_dat_i;
          5'h0C: {stage_q.acols, stage_q.rows} <= wb_dat_i;
          5'h10: stage_q.cols <= wb_dat_i[15:0];
          default: ;
        endcase
      end
      if (push_ok) begin
        q_mem[tail_q] <= stage_q;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      if (push_ok && !pop) cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
      if (retire) done_cnt_q <= done_cnt_q + 32'd1;
      // Hardware set events win over a CPU clear in the same cycle.
      if (cmd_wr && wb_dat_i[1]) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (retire) done_q <= 1'b1;
      if (tmo_hit) err_q <= 1'b1;
      if (cmd_wr && wb_dat_i[2]) ovf_q <= 1'b0;
      if (push_req && full) ovf_q <= 1'b1;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign m_stb_o  = m_stb_q;
  assign m_we_o   = m_we_q;
  assign m_adr_o  = m_adr_q;
  assign m_dat_o  = m_dat_q;
  assign irq_o    = done_q | err_q;

endmodule

// File: tb/tb_matrix_job_scheduler.sv
// Bench for matrix_job_scheduler: accelerator model plus scoreboards
// for master writes and CPU reads.
module tb_matrix_job_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic        m_we_o, m_stb_o;
  logic        m_ack_i = 1'b0;
  logic        irq_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  matrix_job_scheduler #(
    .QUEUE_DEPTH(4),
    .POLL_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i),
    .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i),
    .m_we_o(m_we_o),
    .m_stb_o(m_stb_o),
    .m_ack_i(m_ack_i),
    .irq_o(irq_o)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  string       exp_nm[$];
  wr_t         mon_e;
  logic [31:0] cpu_e;
  string       cpu_n;

  int   delay = 0;
  int   wcnt = 0;
  int   done_lat = 2;
  int   pcnt = 0;
  int   starts = 0;
  int   stuck = 0;
  int   stuck_polls = 0;
  int   wr_cnt = 0;
  logic ctrl = 1'b0;
  bit   mon_en = 1'b1;
  logic p_stb = 0, p_ack = 0, p_we = 0;
  logic [31:0] p_adr = 0, p_dat = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      p_stb = 0;
      p_ack = 0;
      m_ack_i = 0;
      wcnt = 0;
    end else begin
      if (p_stb && p_ack) begin
        if (p_we) begin
          wr_cnt++;
          if (p_adr == 32'h0) begin
            ctrl = p_dat[0];
            if (p_dat[0]) begin
              starts++;
              pcnt = 0;
            end
          end
          if (exp_wr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL m_wr_extra: got %h=%h want none",
                     p_adr, p_dat);
          end else begin
            mon_e = exp_wr.pop_front();
            chk("m_wr_adr", p_adr, mon_e.adr);
            chk("m_wr_dat", p_dat, mon_e.dat);
          end
        end else begin
          chk("m_rd_adr", p_adr, 32'h16);
        end
        chk("m_stb_gap", {31'd0, m_stb_o}, 32'd0);
      end else if (p_stb) begin
        chk("m_hold_stb", {30'd0, m_stb_o, m_we_o},
            {30'd0, 1'b1, p_we});
        chk("m_hold_adr", m_adr_o, p_adr);
        chk("m_hold_dat", m_dat_o, p_dat);
      end
      if (m_stb_o) begin
        if (wcnt >= delay) begin
          if (!m_ack_i && !m_we_o) begin
            if (!ctrl) m_dat_i = 32'd0;
            else if (starts == stuck) begin
              m_dat_i = 32'd1;
              stuck_polls++;
            end else if (pcnt >= done_lat) m_dat_i = 32'd2;
            else begin
              pcnt++;
              m_dat_i = 32'd1;
            end
          end
          m_ack_i = 1'b1;
        end else begin
          m_ack_i = 1'b0;
        end
        wcnt++;
      end else begin
        m_ack_i = 1'b0;
        wcnt = 0;
      end
      p_stb = m_stb_o;
      p_ack = m_ack_i;
      p_we  = m_we_o;
      p_adr = m_adr_o;
      p_dat = m_dat_o;
    end
  end

  always @(negedge clk) begin
    if (wb_ack_o && !wb_we_i) begin
      if (exp_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cpu_rd_extra: got %h want none", wb_dat_o);
      end else begin
        cpu_e = exp_rd.pop_front();
        cpu_n = exp_nm.pop_front();
        chk(cpu_n, wb_dat_o, cpu_e);
      end
    end
  end

  task automatic cpu_acc(input logic [31:0] a,
                         input logic [31:0] d,
                         input logic we);
    int n;
    @(negedge clk);
    #2;
    wb_adr_i = a;
    wb_dat_i = d;
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!wb_ack_o && n < 20);
    if (!wb_ack_o) begin
      total++;
      bad++;
      $display("FAIL cpu_ack: got 0 want 1 adr=%h", a);
    end
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic cpu_rd(input logic [31:0] a,
                        input logic [31:0] e,
                        input string nm);
    exp_rd.push_back(e);
    exp_nm.push_back(nm);
    cpu_acc(a, 32'h0, 1'b0);
  endtask

  task automatic push_job(input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] c,
                          input logic [15:0] r,
                          input logic [15:0] ac,
                          input logic [15:0] co,
                          input bit runs);
    if (runs) begin
      exp_wr.push_back({32'h04, a});
      exp_wr.push_back({32'h08, b});
      exp_wr.push_back({32'h0C, c});
      exp_wr.push_back({32'h10, 16'd0, r});
      exp_wr.push_back({32'h12, 16'd0, ac});
      exp_wr.push_back({32'h14, 16'd0, co});
      exp_wr.push_back({32'h00, 32'd1});
      exp_wr.push_back({32'h00, 32'd0});
    end
    cpu_acc(32'h00, a, 1'b1);
    cpu_acc(32'h04, b, 1'b1);
    cpu_acc(32'h08, c, 1'b1);
    cpu_acc(32'h0C, {ac, r}, 1'b1);
    cpu_acc(32'h10, {16'd0, co}, 1'b1);
    cpu_acc(32'h14, 32'd1, 1'b1);
  endtask

  task automatic wait_wr(input int n, input string nm);
    int k;
    k = 0;
    while (wr_cnt < n && k < 5000) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (wr_cnt < n) begin
      bad++;
      $display("FAIL %s: got %0d writes want %0d", nm, wr_cnt, n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    logic [31:0] kk;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_stb", {31'd0, m_stb_o}, 32'd0);
    chk("rst_wb_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cpu_rd(32'h18, 32'h2, "status_rst");
    cpu_rd(32'h1C, 32'h0, "dcnt_rst");
    cpu_rd(32'h02, 32'hDEADBEEF, "unmapped");

    base = wr_cnt;
    push_job(32'h1000, 32'h2000, 32'h3000,
             16'd2, 16'd8, 16'd2, 1'b1);
    cpu_rd(32'h00, 32'h1000, "a_rb");
    cpu_rd(32'h0C, 32'h00080002, "dims_rb");
    cpu_rd(32'h10, 32'h2, "cols_rb");
    wait_wr(base + 8, "job1_wait");
    idle(10);
    chk("irq_done", {31'd0, irq_o}, 32'd1);
    cpu_rd(32'h1C, 32'd1, "dcnt_1");
    cpu_rd(32'h18, 32'h0A, "status_done");
    cpu_acc(32'h14, 32'h2, 1'b1);
    chk("irq_clr", {31'd0, irq_o}, 32'd0);
    cpu_rd(32'h18, 32'h02, "status_clr");

    delay = 40;
    base = wr_cnt;
    for (k = 1; k <= 4; k++) begin
      kk = 32'(k);
      push_job(32'hA000_0000 | kk, 32'hB000_0000 | kk,
               32'hC000_0000 | kk, kk[15:0],
               kk[15:0] + 16'd8, kk[15:0] + 16'd16, 1'b1);
    end
    cpu_rd(32'h18, 32'h0405, "status_full");
    push_job(32'hA5, 32'hB5, 32'hC5, 16'd5,
             16'd13, 16'd21, 1'b0);
    cpu_rd(32'h18, 32'h0425, "status_ovf");
    delay = 0;
    wait_wr(base + 32, "fill_wait");
    idle(15);
    cpu_rd(32'h1C, 32'd5, "dcnt_5");
    cpu_rd(32'h18, 32'h2A, "status_fill");
    cpu_acc(32'h14, 32'h6, 1'b1);
    cpu_rd(32'h18, 32'h02, "status_clr2");

    delay = 3;
    base = wr_cnt;
    push_job(32'h4444, 32'h5555, 32'h6666,
             16'd3, 16'd4, 16'd5, 1'b1);
    wait_wr(base + 8, "held_wait");
    idle(20);
    cpu_rd(32'h1C, 32'd6, "dcnt_6");
    chk("irq_held", {31'd0, irq_o}, 32'd1);
    cpu_acc(32'h14, 32'h2, 1'b1);
    delay = 0;

    stuck = starts + 1;
    stuck_polls = 0;
    base = wr_cnt;
    push_job(32'h7000, 32'h7100, 32'h7200,
             16'd1, 16'd1, 16'd1, 1'b1);
    push_job(32'h8000, 32'h8100, 32'h8200,
             16'd2, 16'd2, 16'd2, 1'b1);
    wait_wr(base + 16, "tmo_wait");
    idle(15);
    chk("tmo_polls", 32'(stuck_polls), 32'd10);
    cpu_rd(32'h1C, 32'd7, "dcnt_tmo");
    cpu_rd(32'h18, 32'h1A, "status_err");
    chk("irq_err", {31'd0, irq_o}, 32'd1);

    delay = 2;
    base = wr_cnt;
    push_job(32'h9000, 32'h9100, 32'h9200,
             16'd6, 16'd7, 16'd8, 1'b1);
    wait_wr(base + 3, "cfg3_wait");
    k = 0;
    while (!m_stb_o && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("cfg4_stb", {31'd0, m_stb_o}, 32'd1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mrst_stb", {31'd0, m_stb_o}, 32'd0);
    chk("mrst_we", {31'd0, m_we_o}, 32'd0);
    chk("mrst_adr", m_adr_o, 32'd0);
    chk("mrst_dat", m_dat_o, 32'd0);
    chk("mrst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("mrst_wbdat", wb_dat_o, 32'd0);
    chk("mrst_irq", {31'd0, irq_o}, 32'd0);
    exp_wr.delete();
    idle(2);
    reset_n = 1'b1;
    mon_en = 1'b1;
    delay = 0;
    cpu_rd(32'h18, 32'h2, "status_mrst");
    cpu_rd(32'h1C, 32'h0, "dcnt_mrst");
    cpu_rd(32'h00, 32'h0, "a_mrst");

    base = wr_cnt;
    push_job(32'hE000, 32'hE100, 32'hE200,
             16'd9, 16'd9, 16'd9, 1'b1);
    wait_wr(base + 8, "post_wait");
    idle(10);
    cpu_rd(32'h1C, 32'd1, "dcnt_post");

    idle(5);
    chk("exp_wr_left", 32'(exp_wr.size()), 32'd0);
    chk("exp_rd_left", 32'(exp_rd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
